if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Parametrised instruction-fetch stage for the RISC-V pipeline, successor to the single-register IF block. Holds the fetch PC, issues sequential requests to a synchronous instruction memory, and buffers returned instructions with their PCs in a small fetch queue. It presents them to decode through a valid/ready handshake. Supports branch/jump redirect with queue flush, backpressure from decode, and an optional misaligned-target trap.

## Interface
Parameters:
- XLEN, 64, PC width in bits.
- ILEN, 32, instruction width in bits.
- RESET_PC, 0, fetch PC after reset (must be 4-byte aligned).
- FQ_DEPTH, 4, fetch-queue entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request to instruction memory this cycle.
- imem_addr  out  XLEN  byte address of request (equals fetch_pc).
- imem_rdata  in  ILEN  instruction data, valid exactly one cycle after imem_req.
- redirect_valid  in  1  load new PC (taken branch/jump/trap vector).
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  ILEN  head instruction.
- out_pc  out  XLEN  head PC.
- out_pc_next  out  XLEN  out_pc + 4, modulo 2^XLEN.
- misalign_err  out  1  fetch halted on misaligned redirect (tied 0 when feature disabled).

## Operation
- State machine: RUN, HALT. Reset enters RUN. HALT exists only with IF_MISALIGN_TRAP_EN.
- Issue (RUN, no redirect this cycle): imem_req=1 when count + inflight < FQ_DEPTH. count is queue occupancy at cycle start; a same-cycle pop is not credited. On issue, fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN. inflight <= 1 and req_pc <= fetch_pc are registered.
- Response: in the cycle after an issue, {req_pc, imem_rdata} is pushed into the queue unless a redirect occurs in that cycle.
- Pop: out_valid && out_ready removes the head. Push and pop in the same cycle are legal at any occupancy, including full.
- Redirect has priority over all other events in its cycle:
  - queue cleared (count <= 0);
  - inflight response discarded;
  - fetch_pc <= redirect_pc;
  - no request issued that cycle;
  - a pop in that cycle is ignored.
- Queue never overflows: the issue credit rule guarantees a free slot for every in-flight response.
- Reset mid-operation: queue emptied, inflight cleared, fetch_pc <= RESET_PC, state RUN, all outputs to reset values immediately (asynchronous).

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_pc_next=4, misalign_err=0.
- First edge after reset release is cycle 0: request at RESET_PC. Response pushed at end of cycle 1. out_valid=1 in cycle 2.
- Redirect in cycle R: request to target in R+1, out_valid for target in R+3. Fetch-to-decode latency is 2 cycles.
- Throughput: 1 instr/cycle with out_ready held high and FQ_DEPTH >= 4. With FQ_DEPTH=2, at most 1 instr per 2 cycles.
- out_valid, out_instr, out_pc and out_pc_next are driven from registered queue state. There is no combinational path from out_ready or redirect_valid to any output.

## Configuration
- IF_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0] != 0 still flushes the queue and loads fetch_pc, then enters HALT.
  - In HALT: misalign_err=1, imem_req=0, queue stays empty.
  - An aligned redirect returns to RUN and clears misalign_err in the same edge.
  - A misaligned redirect while in HALT stays in HALT.
  - Reset exits HALT.
- IF_MISALIGN_TRAP_EN undefined: redirect_pc[1:0] is forced to 00 when loaded, misalign_err is constant 0, and no HALT state exists.

## Test plan
- Reset release, RESET_PC=2000, out_ready=1: out_valid rises in cycle 2; out_pc sequence 2000, 2004, 2008… with no bubbles; out_pc_next = out_pc+4.
- Redirect to 3000 while the queue holds 3 entries: queue empties next cycle, no stale PC appears, first out_pc=3000 exactly 3 cycles after the redirect.
- out_ready=0 for 10 cycles: imem_req stops once count+inflight=FQ_DEPTH (4 entries queued). Then set out_ready=1: order 2000..2012 preserved, no loss or duplicate.
- Redirect in the same cycle as an in-flight response and a pop: the response is dropped, the pop is ignored, and the next out_pc equals the target (6100).
- Reset asserted mid-stream with the queue full: out_valid=0 immediately; after release, the fetch sequence restarts from RESET_PC.
- With IF_MISALIGN_TRAP_EN, redirect to 6102: misalign_err=1 and imem_req=0 held. Then redirect to 6100: misalign_err=0, out_pc=6100 three cycles later. Without the macro, a redirect to 6102 fetches from 6100.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage with fetch PC, synchronous imem requests and a fetch queue.
// Define IF_MISALIGN_TRAP_EN to halt fetch on a misaligned redirect target.
module if_fetch_unit #(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     ILEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     FQ_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [ILEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ILEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_next,
   output logic            misalign_err
);

   localparam int unsigned PW = $clog2(FQ_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fq_entry_t;

   fq_entry_t       fq [FQ_DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_pc;
   logic [XLEN-1:0] load_pc;
   logic            inflight;
   logic            issue;
   logic            push;
   logic            pop;
   logic            run_nxt;

`ifdef IF_MISALIGN_TRAP_EN
   typedef enum logic {RUN, HALT} state_t;
   state_t state;
`endif

   always_comb begin
      issue     = imem_req & ~redirect_valid;
      push      = inflight & ~redirect_valid;
      pop       = out_valid & out_ready & ~redirect_valid;
      count_nxt = redirect_valid ? '0
                : count + CW'(push) - CW'(pop);
`ifdef IF_MISALIGN_TRAP_EN
      load_pc = redirect_pc;
      run_nxt = redirect_valid ? (redirect_pc[1:0] == 2'b00)
              : (state == RUN);
`else
      load_pc = redirect_pc & ~XLEN'(3);
      run_nxt = 1'b1;
`endif
   end

   // imem_req is the credit check evaluated on next-cycle occupancy,
   // so it is registered yet behaves like a start-of-cycle decision.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
         imem_req <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= issue;
         count    <= count_nxt;
         imem_req <= run_nxt &&
                     (32'(count_nxt) + 32'(issue) < FQ_DEPTH);
         if (redirect_valid) begin
            fetch_pc <= load_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (issue) begin
               fetch_pc <= fetch_pc + XLEN'(4);
               req_pc   <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fq[wr_ptr] <= '{pc: req_pc, instr: imem_rdata};
   end

`ifdef IF_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= RUN;
         misalign_err <= 1'b0;
      end else if (redirect_valid) begin
         if (redirect_pc[1:0] != 2'b00) begin
            state        <= HALT;
            misalign_err <= 1'b1;
         end else begin
            state        <= RUN;
            misalign_err <= 1'b0;
         end
      end
   end
`else
   assign misalign_err = 1'b0;
`endif

   assign imem_addr   = fetch_pc;
   assign out_valid   = (count != '0);
   assign out_instr   = out_valid ? fq[rd_ptr].instr : '0;
   assign out_pc      = out_valid ? fq[rd_ptr].pc : '0;
   assign out_pc_next = out_pc + XLEN'(4);

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch order, backpressure,
// redirect flush, async reset and misaligned redirect handling.
module tb_if_fetch_unit;

   localparam logic [63:0] RPC = 64'h2000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic [63:0] out_pc_next;
   logic        misalign_err;

   int nvec = 0;
   int nerr = 0;

   if_fetch_unit #(
      .XLEN(64), .ILEN(32), .RESET_PC(RPC), .FQ_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc),
      .out_pc_next(out_pc_next),
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [63:0] a);
      return {a[15:0], 16'h0013};
   endfunction

   always @(posedge clk) begin
      if (imem_req) imem_rdata <= mk(imem_addr);
   end

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      redirect_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic head(input string tag, input logic [63:0] pc);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_pc"}, out_pc, pc);
      chk({tag, "_pcn"}, out_pc_next, pc + 64'd4);
      chk({tag, "_instr"}, 64'(out_instr), 64'(mk(pc)));
   endtask

   initial begin
      reset          = 1'b0;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 64'(imem_req), 64'd0);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_instr", 64'(out_instr), 64'd0);
      chk("rst_pc", out_pc, 64'd0);
      chk("rst_pcn", out_pc_next, 64'd4);
      chk("rst_mis", 64'(misalign_err), 64'd0);
      reset = 1'b1;

      // streaming from reset
      step();
      chk("c0_req", 64'(imem_req), 64'd1);
      chk("c0_addr", imem_addr, RPC);
      chk("c0_valid", 64'(out_valid), 64'd0);
      step();
      chk("c1_valid", 64'(out_valid), 64'd0);
      chk("c1_addr", imem_addr, RPC + 64'd4);
      step();
      for (int k = 0; k < 6; k++) begin
         head("stream", RPC + 64'(4 * k));
         step();
      end

      // backpressure: four entries queued, then drain in order
      out_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         step();
         chk("bp_req", 64'(imem_req), (c < 4) ? 64'd1 : 64'd0);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         head("bp_drain", RPC + 64'(4 * k));
         step();
      end

      // redirect with three entries queued and a pop offered
      out_ready = 1'b0;
      do_reset();
      repeat (5) step();
      head("rd3_pre", RPC);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3000;
      out_ready      = 1'b1;
      step();
      redirect_valid = 1'b0;
      chk("rd3_flush", 64'(out_valid), 64'd0);
      chk("rd3_req", 64'(imem_req), 64'd1);
      chk("rd3_addr", imem_addr, 64'h3000);
      step();
      chk("rd3_gap", 64'(out_valid), 64'd0);
      step();
      head("rd3_tgt", 64'h3000);
      step();
      head("rd3_tgt4", 64'h3004);

      // redirect colliding with in-flight response and pop
      out_ready = 1'b1;
      do_reset();
      repeat (4) step();
      head("rdc_pre", RPC + 64'd4);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h6100;
      step();
      redirect_valid = 1'b0;
      chk("rdc_drop1", 64'(out_valid), 64'd0);
      step();
      chk("rdc_drop2", 64'(out_valid), 64'd0);
      step();
      head("rdc_tgt", 64'h6100);
      step();
      head("rdc_tgt4", 64'h6104);

      // asynchronous reset with a full queue
      out_ready = 1'b0;
      do_reset();
      repeat (7) step();
      head("full_pre", RPC);
      chk("full_req", 64'(imem_req), 64'd0);
      reset = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_req", 64'(imem_req), 64'd0);
      chk("arst_addr", imem_addr, RPC);
      chk("arst_pc", out_pc, 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      step();
      chk("arst_c0req", 64'(imem_req), 64'd1);
      chk("arst_c0addr", imem_addr, RPC);
      step();
      step();
      head("arst_h0", RPC);
      step();
      head("arst_h1", RPC + 64'd4);

      // misaligned redirect target
      out_ready = 1'b1;
      do_reset();
      repeat (4) step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h6102;
      step();
      redirect_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      for (int k = 0; k < 4; k++) begin
         chk("halt_mis", 64'(misalign_err), 64'd1);
         chk("halt_req", 64'(imem_req), 64'd0);
         chk("halt_valid", 64'(out_valid), 64'd0);
         if (k < 3) step();
      end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h6100;
      step();
      redirect_valid = 1'b0;
      chk("unhalt_mis", 64'(misalign_err), 64'd0);
      chk("unhalt_req", 64'(imem_req), 64'd1);
      chk("unhalt_addr", imem_addr, 64'h6100);
      step();
      step();
      head("unhalt_tgt", 64'h6100);
`else
      chk("mis_err", 64'(misalign_err), 64'd0);
      chk("mis_req", 64'(imem_req), 64'd1);
      chk("mis_addr", imem_addr, 64'h6100);
      step();
      step();
      head("mis_tgt", 64'h6100);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
